// File: rtl/kyber_pkg.sv
// rtl/kyber_pkg.sv - shared Kyber constants and basemul controller state type
package kyber_pkg;

   localparam int KYBER_N   = 256;
   localparam int ADDR_W    = 7;
   localparam int ZETA_BASE = 64;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_START,
      ST_WAIT,
      ST_WRITE,
      ST_DONE
   } bm_state_e;

endpackage

// File: rtl/basemul_ctrl.sv
// rtl/basemul_ctrl.sv - sequencer for a 256-coefficient pointwise basemul pass
module basemul_ctrl
   import kyber_pkg::*;
#(
   parameter int RAM_LAT    = 1,
   parameter int ZETA_BASE  = kyber_pkg::ZETA_BASE,
   parameter int BM_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] in_addra,
   output logic [ADDR_W-1:0] in_addrb,
   output logic              in_re,
   output logic [ADDR_W-1:0] zeta_addr,
   output logic              bm_start,
   input  logic              bm_valid,
   output logic [ADDR_W-1:0] out_addra,
   output logic [ADDR_W-1:0] out_addrb,
   output logic              out_we
);

   // Each iteration handles two words (four coefficients), so 64 iterations.
   localparam int          K_W    = 6;
   localparam logic [K_W-1:0] LAST_K = K_W'(KYBER_N / 4 - 1);
   localparam int          CNT_MAX = (RAM_LAT > BM_TIMEOUT) ? RAM_LAT : BM_TIMEOUT;
   localparam int          CNT_W   = $clog2(CNT_MAX + 1);

   bm_state_e         state_q, state_d;
   logic [K_W-1:0]    k_q, k_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              err_q, err_d;

   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              in_re_q, in_re_d;
   logic              bm_start_q, bm_start_d;
   logic              out_we_q, out_we_d;
   logic [ADDR_W-1:0] in_addra_q, in_addra_d;
   logic [ADDR_W-1:0] in_addrb_q, in_addrb_d;
   logic [ADDR_W-1:0] zeta_addr_q, zeta_addr_d;
   logic [ADDR_W-1:0] out_addra_q, out_addra_d;
   logic [ADDR_W-1:0] out_addrb_q, out_addrb_d;

   // Next state, iteration index, shared fetch/timeout counter and error flag.
   // Outputs are decoded from the next state so registering them adds no lag.
   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_FETCH;
               k_d     = '0;
               cnt_d   = '0;
               err_d   = 1'b0;
            end
         end
         ST_FETCH: begin
            if (cnt_q == CNT_W'(RAM_LAT - 1)) begin
               state_d = ST_START;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_START: begin
            state_d = ST_WAIT;
            cnt_d   = '0;
         end
         ST_WAIT: begin
            // A valid arriving on the last allowed cycle still wins over timeout.
            if (bm_valid) begin
               state_d = ST_WRITE;
            end else if (cnt_q == CNT_W'(BM_TIMEOUT - 1)) begin
               state_d = ST_DONE;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_WRITE: begin
            if (k_q == LAST_K) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_FETCH;
               k_d     = k_q + 1'b1;
               cnt_d   = '0;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      busy_d      = (state_d != ST_IDLE);
      done_d      = (state_d == ST_DONE);
      in_re_d     = (state_d == ST_FETCH);
      bm_start_d  = (state_d == ST_START);
      out_we_d    = (state_d == ST_WRITE);
      in_addra_d  = in_addra_q;
      in_addrb_d  = in_addrb_q;
      zeta_addr_d = zeta_addr_q;
      out_addra_d = out_addra_q;
      out_addrb_d = out_addrb_q;
      if (state_d == ST_FETCH) begin
         in_addra_d  = {k_d, 1'b0};
         in_addrb_d  = {k_d, 1'b1};
         zeta_addr_d = ADDR_W'(ZETA_BASE) + ADDR_W'(k_d);
      end
      if (state_d == ST_WRITE) begin
         out_addra_d = {k_d, 1'b0};
         out_addrb_d = {k_d, 1'b1};
      end
   end

   // State and registered outputs; reset clears everything and aborts a run.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         k_q         <= '0;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         in_re_q     <= 1'b0;
         bm_start_q  <= 1'b0;
         out_we_q    <= 1'b0;
         in_addra_q  <= '0;
         in_addrb_q  <= '0;
         zeta_addr_q <= '0;
         out_addra_q <= '0;
         out_addrb_q <= '0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         in_re_q     <= in_re_d;
         bm_start_q  <= bm_start_d;
         out_we_q    <= out_we_d;
         in_addra_q  <= in_addra_d;
         in_addrb_q  <= in_addrb_d;
         zeta_addr_q <= zeta_addr_d;
         out_addra_q <= out_addra_d;
         out_addrb_q <= out_addrb_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign in_re     = in_re_q;
   assign bm_start  = bm_start_q;
   assign out_we    = out_we_q;
   assign in_addra  = in_addra_q;
   assign in_addrb  = in_addrb_q;
   assign zeta_addr = zeta_addr_q;
   assign out_addra = out_addra_q;
   assign out_addrb = out_addrb_q;

endmodule
